// File: rtl/weight_buffer_stream.sv
// weight_buffer_stream: BANKS run-time loadable weight banks streamed in
// lockstep over a valid/ready interface.
// Build option: define WEIGHT_BUFFER_WRAP_EN to let a stream wrap past the
// last word back to index 0 (index arithmetic modulo DEPTH).
//
// Pipeline: stage A holds the issued index, stage B is the registered RAM
// output (which is also q). A stall freezes both stages and the index counter.
module weight_buffer_stream #(
    parameter int DATA_WIDTH = 18,
    parameter int LANES      = 9,
    parameter int BANKS      = 2,
    parameter int DEPTH      = 42,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              wr_en,
    input  logic [((BANKS > 1) ? $clog2(BANKS) : 1)-1:0]      wr_bank,
    input  logic [ADDR_WIDTH-1:0]                             wr_addr,
    input  logic [LANES*DATA_WIDTH-1:0]                       wr_data,
    input  logic                                              start,
    input  logic [ADDR_WIDTH-1:0]                             start_idx,
    input  logic [ADDR_WIDTH:0]                               len,
    output logic [BANKS*LANES*DATA_WIDTH-1:0]                 q,
    output logic                                              q_valid,
    output logic                                              q_last,
    input  logic                                              q_ready,
    output logic                                              busy,
    output logic                                              reject
);

    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W = LANES * DATA_WIDTH;
    localparam int CNT_W  = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;      // next index to issue
    logic [CNT_W-1:0] rem_q, rem_d;      // indices still to issue
    logic             a_valid_q, a_valid_d;
    logic [IDX_W-1:0] a_idx_q, a_idx_d;
    logic             a_last_q, a_last_d;
    logic             b_valid_q, b_valid_d;
    logic             b_last_q, b_last_d;
    logic             reject_q, reject_d;

    logic busy_w;
    logic in_idle;
    logic start_legal;
    logic range_ok;
    logic accept;
    logic wr_ok;
    logic rd_en;
    logic a_adv;

    // Step an index by one, wrapping at DEPTH only when wrap is built in.
    function automatic logic [CNT_W-1:0] next_idx(input logic [CNT_W-1:0] i);
`ifdef WEIGHT_BUFFER_WRAP_EN
        return (i == LAST_IDX_C) ? '0 : i + ONE_C;
`else
        return i + ONE_C;
`endif
    endfunction

`ifdef WEIGHT_BUFFER_WRAP_EN
    assign range_ok = 1'b1;
`else
    logic [CNT_W:0] end_sum;
    assign end_sum  = {2'b00, start_idx} + {1'b0, len};
    assign range_ok = (end_sum <= {1'b0, DEPTH_C});
`endif

    assign busy_w      = (state_q == ST_RUN) | a_valid_q | b_valid_q;
    assign in_idle     = (state_q == ST_IDLE);
    assign start_legal = (len != '0) && (len <= DEPTH_C) &&
                         ({1'b0, start_idx} < DEPTH_C) && range_ok;
    assign wr_ok       = wr_en & in_idle & ~busy_w & ({1'b0, wr_addr} < DEPTH_C);
    // A simultaneous write wins; the start is then refused.
    assign accept      = start & in_idle & ~busy_w & start_legal & ~wr_en;
    assign rd_en       = a_valid_q & (~b_valid_q | q_ready);
    assign a_adv       = ~a_valid_q | rd_en;

    // Next-state logic for the FSM, index counter and both pipeline stages.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        a_valid_d = a_valid_q;
        a_idx_d   = a_idx_q;
        a_last_d  = a_last_q;
        b_valid_d = b_valid_q;
        b_last_d  = b_last_q;
        reject_d  = (wr_en & ~wr_ok) | (start & in_idle & ~accept);

        if (rd_en) begin
            b_valid_d = 1'b1;
            b_last_d  = a_last_q;
        end else if (q_ready) begin
            b_valid_d = 1'b0;
            b_last_d  = 1'b0;
        end

        if (a_adv) begin
            if (accept) begin
                // First index goes straight into stage A so data appears two cycles later.
                a_valid_d = 1'b1;
                a_idx_d   = start_idx[IDX_W-1:0];
                a_last_d  = (len == ONE_C);
                idx_d     = next_idx({1'b0, start_idx});
                rem_d     = len - ONE_C;
                state_d   = (len == ONE_C) ? ST_IDLE : ST_RUN;
            end else if (state_q == ST_RUN) begin
                a_valid_d = 1'b1;
                a_idx_d   = idx_q[IDX_W-1:0];
                a_last_d  = (rem_q == ONE_C);
                idx_d     = next_idx(idx_q);
                rem_d     = rem_q - ONE_C;
                if (rem_q == ONE_C) begin
                    state_d = ST_IDLE;
                end
            end else begin
                a_valid_d = 1'b0;
                a_last_d  = 1'b0;
            end
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            rem_q     <= '0;
            a_valid_q <= 1'b0;
            a_idx_q   <= '0;
            a_last_q  <= 1'b0;
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
            reject_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            a_valid_q <= a_valid_d;
            a_idx_q   <= a_idx_d;
            a_last_q  <= a_last_d;
            b_valid_q <= b_valid_d;
            b_last_q  <= b_last_d;
            reject_q  <= reject_d;
        end
    end

    // One block RAM per bank; all banks share the read index.
    genvar gi;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            logic [WORD_W-1:0] mem [0:DEPTH-1];
            logic [WORD_W-1:0] rd_q;

            // Write port, enabled only for the addressed bank.
            always_ff @(posedge clk) begin
                if (wr_ok && (wr_bank == BANK_W'(gi))) begin
                    mem[wr_addr[IDX_W-1:0]] <= wr_data;
                end
            end

            // Registered read; holding rd_en low keeps q stable under stall.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_q <= '0;
                end else if (rd_en) begin
                    rd_q <= mem[a_idx_q];
                end
            end

            assign q[gi*WORD_W +: WORD_W] = rd_q;
        end
    endgenerate

    assign q_valid = b_valid_q;
    assign q_last  = b_last_q;
    assign busy    = busy_w;
    assign reject  = reject_q;

endmodule

// File: tb/tb_weight_buffer_stream.sv
// Directed testbench for weight_buffer_stream with immediate assertions.
module tb_weight_buffer_stream;

    localparam int DW = 18;
    localparam int L  = 9;
    localparam int B  = 2;
    localparam int D  = 42;
    localparam int AW = 12;
    localparam int WW = L * DW;
    localparam int QW = B * WW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic [0:0]    wr_bank;
    logic [AW-1:0] wr_addr;
    logic [WW-1:0] wr_data;
    logic          start;
    logic [AW-1:0] start_idx;
    logic [AW:0]   len;
    logic [QW-1:0] q;
    logic          q_valid;
    logic          q_last;
    logic          q_ready;
    logic          busy;
    logic          reject;

    int pass_cnt = 0;
    int total_cnt = 0;

    weight_buffer_stream #(
        .DATA_WIDTH(DW), .LANES(L), .BANKS(B), .DEPTH(D), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_idx(start_idx), .len(len),
        .q(q), .q_valid(q_valid), .q_last(q_last), .q_ready(q_ready),
        .busy(busy), .reject(reject)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chkq(input string tag, input logic [QW-1:0] obs, input logic [QW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [WW-1:0] lanes(input int v);
        logic [WW-1:0] w;
        for (int k = 0; k < L; k++) w[k*DW +: DW] = DW'(v);
        return w;
    endfunction

    function automatic logic [QW-1:0] ws(input int v0, input int v1);
        return {lanes(v1), lanes(v0)};
    endfunction

    // Stream n words from s with q_ready held high and check every word.
    task automatic stream_check(input string tag, input int s, input int n);
        int i;
        start = 1'b1; start_idx = AW'(s); len = (AW+1)'(n);
        tick();
        chk({tag, "_lat_valid"}, 64'(q_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            tick();
            i = (s + k) % D;
            chk($sformatf("%s_valid%0d", tag, k), 64'(q_valid), 64'd1);
            chkq($sformatf("%s_q%0d", tag, k), q, ws(i, i + 100));
            chk($sformatf("%s_last%0d", tag, k), 64'(q_last), 64'(k == n - 1));
        end
        tick();
        chk({tag, "_end_valid"}, 64'(q_valid), 64'd0);
        chk({tag, "_end_busy"}, 64'(busy), 64'd0);
        $display("stream %s start=%0d len=%0d done", tag, s, n);
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_idx = '0; len = '0; q_ready = 1'b1;

        // Reset state
        tick(); tick();
        reset = 1'b0;
        chk("rst_valid", 64'(q_valid), 64'd0);
        chk("rst_last", 64'(q_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_reject", 64'(reject), 64'd0);
        chkq("rst_q", q, '0);
        $display("reset checked");

        // Load both banks
        for (int i = 0; i < D; i++) begin
            for (int b = 0; b < B; b++) begin
                wr_en = 1'b1; wr_bank = 1'(b); wr_addr = AW'(i); wr_data = lanes(i + 100 * b);
                tick();
            end
        end
        wr_en = 1'b0;
        chk("load_reject", 64'(reject), 64'd0);
        $display("load of %0d words per bank done", D);

        // Basic stream
        stream_check("basic", 5, 3);

        // Backpressure: hold q_ready low for 3 cycles after the first word
        start = 1'b1; start_idx = AW'(5); len = (AW+1)'(3);
        tick();
        start = 1'b0; q_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall_valid%0d", c), 64'(q_valid), 64'd1);
            chkq($sformatf("stall_q%0d", c), q, ws(5, 105));
            chk($sformatf("stall_last%0d", c), 64'(q_last), 64'd0);
        end
        q_ready = 1'b1;
        tick();
        chkq("stall_q6", q, ws(6, 106));
        chk("stall_last6", 64'(q_last), 64'd0);
        tick();
        chkq("stall_q7", q, ws(7, 107));
        chk("stall_last7", 64'(q_last), 64'd1);
        tick();
        chk("stall_end_valid", 64'(q_valid), 64'd0);
        chk("stall_end_busy", 64'(busy), 64'd0);
        $display("stall stream done");

        // Illegal starts
        start = 1'b1; start_idx = AW'(0); len = '0;
        tick();
        start = 1'b0;
        chk("len0_reject", 64'(reject), 64'd1);
        chk("len0_busy", 64'(busy), 64'd0);
        tick();
        chk("len0_reject_pulse", 64'(reject), 64'd0);
        chk("len0_valid", 64'(q_valid), 64'd0);
        start = 1'b1; start_idx = AW'(42); len = (AW+1)'(1);
        tick();
        start = 1'b0;
        chk("idx42_reject", 64'(reject), 64'd1);
        chk("idx42_busy", 64'(busy), 64'd0);
        tick();
        chk("idx42_valid", 64'(q_valid), 64'd0);
        $display("illegal starts done");

        // Write during RUN is refused and does not corrupt word 6
        start = 1'b1; start_idx = AW'(5); len = (AW+1)'(3);
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = AW'(6); wr_data = lanes(18'h3FFFF);
        tick();
        wr_en = 1'b0;
        chk("wrrun_reject", 64'(reject), 64'd1);
        chkq("wrrun_q5", q, ws(5, 105));
        tick();
        chkq("wrrun_q6", q, ws(6, 106));
        tick();
        chkq("wrrun_q7", q, ws(7, 107));
        chk("wrrun_last7", 64'(q_last), 64'd1);
        tick();
        chk("wrrun_end_busy", 64'(busy), 64'd0);
        $display("write during run done");

        // Wrap request
`ifdef WEIGHT_BUFFER_WRAP_EN
        stream_check("wrap", 40, 4);
`else
        start = 1'b1; start_idx = AW'(40); len = (AW+1)'(4);
        tick();
        start = 1'b0;
        chk("nowrap_reject", 64'(reject), 64'd1);
        chk("nowrap_busy", 64'(busy), 64'd0);
        tick();
        chk("nowrap_valid", 64'(q_valid), 64'd0);
        tick();
        chk("nowrap_valid2", 64'(q_valid), 64'd0);
        $display("wrap request refused");
`endif

        // Read-after-write: write at t, start at t+1
        wr_en = 1'b1; wr_bank = 1'b0; wr_addr = AW'(10); wr_data = lanes(777);
        tick();
        wr_en = 1'b0;
        start = 1'b1; start_idx = AW'(10); len = (AW+1)'(1);
        tick();
        start = 1'b0;
        chk("raw_reject", 64'(reject), 64'd0);
        tick();
        chk("raw_valid", 64'(q_valid), 64'd1);
        chkq("raw_q", q, ws(777, 110));
        chk("raw_last", 64'(q_last), 64'd1);
        tick();
        chk("raw_end_busy", 64'(busy), 64'd0);
        $display("read-after-write done");

        // Reset mid-stream right after the second word
        start = 1'b1; start_idx = AW'(5); len = (AW+1)'(3);
        tick();
        start = 1'b0;
        tick();
        chkq("rstmid_q5", q, ws(5, 105));
        tick();
        chkq("rstmid_q6", q, ws(6, 106));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid_valid", 64'(q_valid), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_last", 64'(q_last), 64'd0);
        tick();
        chk("rstmid_valid2", 64'(q_valid), 64'd0);
        $display("reset mid-stream done");
        stream_check("after_rst", 0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
